message_composer: RTL and testbench
===================================

# message_composer

Line editor and scrollback store feeding the text display stage. It turns the keyboard's ASCII byte stream into the 16-character input line and keeps the 5-line outgoing-message history. Both are presented as packed strings to the screen layout block. On Enter, the current line is committed to the history and offered to the link transmitter through a valid/ready handshake.

## Interface
- NCHAR, 16, characters per line.
- NLINES, 5, outgoing history depth.
- clock_65mhz  in  1  system pixel clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- char_valid  in  1  one-cycle strobe: char_in holds a new keystroke.
- char_in  in  8  ASCII code of the keystroke.
- keyboard  out  NCHAR*8  current input line. Character 0 (leftmost) is in bits [127:120]; unused positions are 8'h20.
- messageout  out  NLINES*NCHAR*8  history. Line i is in [128*(i+1)-1 : 128*i]; line 0 is the oldest (top of screen), line 4 the newest.
- line_len  out  5  number of characters in the input line, 0..16.
- send_valid  out  1  committed line available for transmit.
- send_data  out  NCHAR*8  committed line, same packing as keyboard; stable while send_valid=1.
- send_ready  in  1  transmitter accepts send_data when send_valid & send_ready.

## Operation
- Reset values:
  - keyboard = all 8'h20.
  - messageout = all 8'h20.
  - line_len = 0.
  - send_valid = 0.
  - send_data = all 8'h20.
- Keystroke classes. A keystroke is acted on only when char_valid=1:
  - Printable (0x20..0x7E): if line_len<16, write the char at position line_len and increment line_len; if line_len==16, drop it.
  - Backspace (0x08): if line_len>0, decrement line_len and write 8'h20 at the new line_len position; else no effect.
  - Escape (0x1B): set every position to 8'h20 and line_len to 0.
  - Enter (0x0D): commit, only if line_len>0 and send_valid==0; otherwise ignored and the line is kept.
  - All other codes are ignored.
- Commit, in one cycle:
  - Each history line i moves to line i-1 for i=1..4; the old line 0 is discarded.
  - Line 4 takes the current input line.
  - send_data takes the input line and send_valid is set.
  - The input line is cleared to spaces and line_len to 0.
- Handshake:
  - send_valid stays high until a cycle with send_ready=1, then clears on the next edge.
  - send_data does not change while send_valid=1.
  - Editing (printable, backspace, escape) continues while a send is pending.
- Simultaneous events:
  - Enter arriving in the same cycle as a completing handshake is still ignored, because the rule tests the registered send_valid.
  - send_ready while send_valid=0 has no effect.
- Reset mid-operation clears everything asynchronously; a pending send is lost.

## Timing
- One keystroke is processed per cycle; back-to-back char_valid is legal.
- Latency: all outputs reflect a keystroke on the edge that samples it, so they are visible one cycle after the char_valid cycle.
- Commit latency: 1 cycle to messageout, send_valid and the cleared keyboard.
- All outputs are registered; no combinational path from inputs to outputs.
- send_valid high time is at least 1 cycle and is unbounded until send_ready.

## Structure
- Shared package holds:
  - ASCII constants: SPACE=8'h20, BKSP=8'h08, ENTER=8'h0D, ESC=8'h1B, PRINT_LO=8'h20, PRINT_HI=8'h7E.
  - NCHAR and NLINES.
  - The line-width constant NCHAR*8.
  - The history packing convention.
- Sub-module line_editor (input line, line_len, keystroke decode). Instantiated once; message_composer adds the history shift register and the send handshake.

## Test plan
- Reset, then type 'H','I' on consecutive cycles -> keyboard[127:112]="HI", rest spaces, line_len=2.
- Type 17 printable chars -> only the first 16 are kept; line_len=16; the 17th is dropped. Then Backspace -> position 15 = 8'h20, line_len=15.
- Type "A", Enter with send_ready=0 -> messageout line 4="A" followed by 15 spaces; send_valid=1; keyboard all spaces. Type "B", Enter -> ignored: line stays "B", line_len=1, history unchanged. Raise send_ready for 1 cycle -> send_valid=0 next cycle.
- Commit six lines "1".."6", with send_ready held at 1 -> lines 0..4 = "2","3","4","5","6"; "1" is gone.
- Enter with line_len=0; ESC after "XYZ"; code 0x07 -> no commit; keyboard all spaces with line_len=0 after ESC; 0x07 causes no change.
- Assert reset_n=0 asynchronously while send_valid=1 and the history is full -> all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/message_composer_pkg.sv
// Shared constants, types and key decode for the message composer slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package message_composer_pkg;

  localparam int NCHAR  = 16;
  localparam int NLINES = 5;
  localparam int LINE_W = NCHAR * 8;
  localparam int HIST_W = NLINES * LINE_W;
  localparam int LEN_W  = 5;

  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] BKSP     = 8'h08;
  localparam logic [7:0] ENTER    = 8'h0D;
  localparam logic [7:0] ESC      = 8'h1B;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  // A line packs character 0 (leftmost) into the most significant byte.
  typedef logic [LINE_W-1:0] line_t;

  // History packing: line i occupies [LINE_W*(i+1)-1 : LINE_W*i];
  // line 0 is the oldest, line NLINES-1 the newest.
  typedef logic [NLINES-1:0][LINE_W-1:0] hist_t;

  localparam line_t BLANK_LINE = {NCHAR{SPACE}};

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_PRINT,
    KEY_BKSP,
    KEY_ESC,
    KEY_ENTER
  } key_class_t;

  function automatic key_class_t classify(input logic [7:0] c);
    key_class_t k;
    k = KEY_NONE;
    if (c >= PRINT_LO && c <= PRINT_HI) k = KEY_PRINT;
    else if (c == BKSP)                 k = KEY_BKSP;
    else if (c == ESC)                  k = KEY_ESC;
    else if (c == ENTER)                k = KEY_ENTER;
    return k;
  endfunction

endpackage

// File: rtl/message_composer_line_editor.sv
// Input line editor: decodes keystrokes into a 16-char line and its length.
// Latency: line/len update on the edge that samples char_valid; enter is combinational.
// Backpressure: none; one keystroke per cycle, clear (commit) overrides the keystroke.
module line_editor
  import message_composer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             char_valid,
  input  logic [7:0]       char_in,
  input  logic             clear,
  output line_t            line,
  output logic [LEN_W-1:0] len,
  output logic             enter
);

  // Ascending index so chars[0] lands in the leftmost (most significant) byte.
  logic [0:NCHAR-1][7:0] chars;
  key_class_t            kc;
  logic [3:0]            wr_idx;
  logic [3:0]            bk_idx;

  assign kc     = classify(char_in);
  assign enter  = char_valid && (kc == KEY_ENTER);
  assign wr_idx = len[3:0];
  assign bk_idx = len[3:0] - 4'd1;
  assign line   = chars;

  // Line buffer and length: commit clear wins, otherwise apply the keystroke.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chars <= BLANK_LINE;
      len   <= '0;
    end else if (clear) begin
      chars <= BLANK_LINE;
      len   <= '0;
    end else if (char_valid) begin
      case (kc)
        KEY_PRINT: begin
          if (len < LEN_W'(NCHAR)) begin
            chars[wr_idx] <= char_in;
            len           <= len + LEN_W'(1);
          end
        end
        KEY_BKSP: begin
          if (len != '0) begin
            chars[bk_idx] <= SPACE;
            len           <= len - LEN_W'(1);
          end
        end
        KEY_ESC: begin
          chars <= BLANK_LINE;
          len   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/message_composer.sv
// Line editor plus 5-line outgoing history and a valid/ready send port.
// Latency: all outputs registered; keystroke/commit visible 1 cycle after char_valid.
// Backpressure: Enter is ignored while a send is pending; editing continues meanwhile.
module message_composer
  import message_composer_pkg::*;
(
  input  logic              clock_65mhz,
  input  logic              reset_n,
  input  logic              char_valid,
  input  logic [7:0]        char_in,
  output logic [LINE_W-1:0] keyboard,
  output logic [HIST_W-1:0] messageout,
  output logic [LEN_W-1:0]  line_len,
  output logic              send_valid,
  output logic [LINE_W-1:0] send_data,
  input  logic              send_ready
);

  line_t cur_line;
  hist_t hist;
  logic  enter;
  logic  commit;

  // Commit only a non-empty line, and only when the previous send has drained
  // as of the registered send_valid (a same-cycle handshake does not help).
  assign commit = enter && (line_len != '0) && !send_valid;

  line_editor u_line_editor (
    .clk        (clock_65mhz),
    .rst_n      (reset_n),
    .char_valid (char_valid),
    .char_in    (char_in),
    .clear      (commit),
    .line       (cur_line),
    .len        (line_len),
    .enter      (enter)
  );

  assign keyboard   = cur_line;
  assign messageout = hist;

  // History shift register: newest line enters at the top slot, oldest falls out.
  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      hist <= {NLINES{BLANK_LINE}};
    end else if (commit) begin
      hist <= {cur_line, hist[NLINES-1:1]};
    end
  end

  // Send handshake: hold data while valid, drop valid after an accepted beat.
  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      send_valid <= 1'b0;
      send_data  <= BLANK_LINE;
    end else if (commit) begin
      send_valid <= 1'b1;
      send_data  <= cur_line;
    end else if (send_valid && send_ready) begin
      send_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_message_composer.sv
module tb_message_composer;

  logic         clock_65mhz = 1'b0;
  logic         reset_n;
  logic         char_valid;
  logic [7:0]   char_in;
  logic [127:0] keyboard;
  logic [639:0] messageout;
  logic [4:0]   line_len;
  logic         send_valid;
  logic [127:0] send_data;
  logic         send_ready;

  int errors = 0;
  int checks = 0;

  // Reference model: plain character arrays and counters.
  logic [7:0] m_line [16];
  int         m_len;
  logic [7:0] m_hist [5][16];
  bit         m_sv;
  logic [7:0] m_sd   [16];

  message_composer dut (
    .clock_65mhz (clock_65mhz),
    .reset_n     (reset_n),
    .char_valid  (char_valid),
    .char_in     (char_in),
    .keyboard    (keyboard),
    .messageout  (messageout),
    .line_len    (line_len),
    .send_valid  (send_valid),
    .send_data   (send_data),
    .send_ready  (send_ready)
  );

  always #5 clock_65mhz = ~clock_65mhz;

  function automatic logic [127:0] pack_line(input logic [7:0] a [16]);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[127-8*k -: 8] = a[k];
    return v;
  endfunction

  function automatic logic [639:0] pack_hist();
    logic [639:0] v;
    for (int i = 0; i < 5; i++) v[128*i +: 128] = pack_line(m_hist[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_line[k] = 8'h20;
      m_sd[k]   = 8'h20;
      for (int i = 0; i < 5; i++) m_hist[i][k] = 8'h20;
    end
    m_len = 0;
    m_sv  = 0;
  endtask

  task automatic model_key(input bit v, input logic [7:0] ch, input bit rdy);
    bit do_commit;
    do_commit = 0;
    if (v) begin
      if (ch >= 8'h20 && ch <= 8'h7E) begin
        if (m_len < 16) begin
          m_line[m_len] = ch;
          m_len++;
        end
      end else if (ch == 8'h08) begin
        if (m_len > 0) begin
          m_len--;
          m_line[m_len] = 8'h20;
        end
      end else if (ch == 8'h1B) begin
        for (int k = 0; k < 16; k++) m_line[k] = 8'h20;
        m_len = 0;
      end else if (ch == 8'h0D) begin
        do_commit = (m_len > 0) && !m_sv;
      end
    end
    if (m_sv && rdy) m_sv = 0;
    if (do_commit) begin
      for (int i = 0; i < 4; i++) m_hist[i] = m_hist[i+1];
      m_hist[4] = m_line;
      m_sd      = m_line;
      m_sv      = 1;
      for (int k = 0; k < 16; k++) m_line[k] = 8'h20;
      m_len = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".keyboard"},   640'(keyboard),   640'(pack_line(m_line)));
    chk({where, ".line_len"},   640'(line_len),   640'(m_len));
    chk({where, ".messageout"}, messageout,       pack_hist());
    chk({where, ".send_valid"}, 640'(send_valid), 640'(m_sv));
    chk({where, ".send_data"},  640'(send_data),  640'(pack_line(m_sd)));
  endtask

  task automatic step(input bit v, input logic [7:0] ch, input bit rdy, input string where);
    char_valid = v;
    char_in    = ch;
    send_ready = rdy;
    @(posedge clock_65mhz);
    model_key(v, ch, rdy);
    #1;
    check_all(where);
  endtask

  task automatic type_str(input string s, input bit rdy, input string where);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], rdy, where);
  endtask

  initial begin
    logic [7:0] rc;
    bit         rv;
    bit         rr;
    int         sel;

    char_valid = 0;
    char_in    = 8'h00;
    send_ready = 0;
    reset_n    = 1;
    model_reset();
    #2 reset_n = 0;
    @(posedge clock_65mhz);
    #1;
    check_all("reset");
    reset_n = 1;

    // Two consecutive printable keystrokes.
    type_str("HI", 1'b0, "hi");
    chk("hi_prefix", 640'(keyboard[127:112]), 640'(16'h4849));
    chk("hi_tail",   640'(keyboard[111:0]),   640'({14{8'h20}}));
    chk("hi_len",    640'(line_len),          640'(5'd2));
    step(1'b1, 8'h1B, 1'b0, "esc0");

    // Overflow: the 17th character is dropped, then backspace.
    type_str("ABCDEFGHIJKLMNOPQ", 1'b0, "fill");
    chk("full_len",  640'(line_len),        640'(5'd16));
    chk("full_last", 640'(keyboard[7:0]),   640'(8'h50));
    step(1'b1, 8'h08, 1'b0, "bksp");
    chk("bksp_pos15", 640'(keyboard[7:0]), 640'(8'h20));
    chk("bksp_len",   640'(line_len),      640'(5'd15));
    step(1'b1, 8'h1B, 1'b0, "esc1");

    // Commit with no ready, then a blocked Enter.
    type_str("A", 1'b0, "a");
    step(1'b1, 8'h0D, 1'b0, "commit_a");
    chk("a_valid", 640'(send_valid),          640'(1'b1));
    chk("a_line4", 640'(messageout[639:512]), 640'({8'h41, {15{8'h20}}}));
    chk("a_kbd",   640'(keyboard),            640'({16{8'h20}}));
    type_str("B", 1'b0, "b");
    step(1'b1, 8'h0D, 1'b0, "enter_blocked");
    chk("b_len", 640'(line_len), 640'(5'd1));
    // Enter together with the completing handshake is still ignored.
    step(1'b1, 8'h0D, 1'b1, "enter_with_ready");
    chk("hs_valid", 640'(send_valid), 640'(1'b0));
    chk("hs_len",   640'(line_len),   640'(5'd1));
    step(1'b0, 8'h00, 1'b1, "ready_idle");
    step(1'b1, 8'h1B, 1'b0, "esc2");

    // Six commits with ready held: oldest line is discarded.
    for (int d = 1; d <= 6; d++) begin
      step(1'b1, 8'(8'h30 + d), 1'b1, "six_char");
      step(1'b1, 8'h0D, 1'b1, "six_enter");
    end
    chk("six_line0", 640'(messageout[127:120]), 640'(8'h32));
    chk("six_line4", 640'(messageout[639:632]), 640'(8'h36));
    step(1'b0, 8'h00, 1'b1, "six_drain");

    // Empty Enter, ESC clearing, and an ignored control code.
    step(1'b1, 8'h0D, 1'b0, "enter_empty");
    chk("empty_valid", 640'(send_valid), 640'(1'b0));
    type_str("XYZ", 1'b0, "xyz");
    step(1'b1, 8'h1B, 1'b0, "esc_xyz");
    chk("esc_len", 640'(line_len), 640'(5'd0));
    type_str("Q", 1'b0, "q");
    step(1'b1, 8'h07, 1'b0, "bell");
    chk("bell_len", 640'(line_len), 640'(5'd1));
    step(1'b1, 8'h1B, 1'b0, "esc3");

    // Randomized keystrokes against the model.
    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      rc = 8'($urandom_range(32, 126));
      else if (sel == 6) rc = 8'h08;
      else if (sel == 7) rc = 8'h0D;
      else if (sel == 8) rc = 8'h1B;
      else               rc = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 255));
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) == 0);
      step(rv, rc, rr, "rand");
    end

    // Fill history, leave a send pending, then reset without a clock edge.
    step(1'b0, 8'h00, 1'b1, "pre_fill");
    for (int d = 0; d < 5; d++) begin
      step(1'b1, 8'(8'h61 + d), 1'b1, "fill_char");
      step(1'b1, 8'h0D, 1'b0, "fill_enter");
      step(1'b0, 8'h00, 1'b1, "fill_drain");
    end
    type_str("ZZ", 1'b0, "zz");
    step(1'b1, 8'h0D, 1'b0, "pend");
    chk("pend_valid", 640'(send_valid), 640'(1'b1));
    reset_n = 0;
    #2;
    model_reset();
    check_all("async_reset");
    chk("ar_valid", 640'(send_valid), 640'(1'b0));
    chk("ar_hist",  messageout,       {80{8'h20}});
    #4;
    reset_n = 1;
    type_str("OK", 1'b0, "post");
    step(1'b1, 8'h0D, 1'b0, "post_commit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
